// File: rtl/au_pkg.sv
// au_pkg: op codes, status codes, flag bit indices and FSM states shared by au_ctrl.
package au_pkg;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;
    typedef enum logic [1:0] {ST_OK = 2'b00, ST_DBZ = 2'b01, ST_TMO = 2'b10} status_e;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
    localparam int F_C   = 0;
    localparam int F_Z   = 1;
    localparam int F_NEG = 2;
    localparam int F_OF  = 3;
endpackage

// File: rtl/au_ctrl.sv
// au_ctrl: one-command-at-a-time controller sequencing an arithmetic unit.
// Accepts a command, drives one AU start level, captures result/flags or aborts on timeout.
module au_ctrl
    import au_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [1:0]  rsp_op,
    output logic [1:0]  rsp_status,
    output logic [7:0]  rsp_cycles,
    output logic [7:0]  au_a,
    output logic [7:0]  au_b,
    output logic        au_startadd,
    output logic        au_startsub,
    output logic        au_startmultiplier,
    output logic        au_startdiv,
    input  logic [15:0] au_result,
    input  logic        au_overflow,
    input  logic        au_negative,
    input  logic        au_zero,
    input  logic        au_carry_out,
    input  logic        au_done
);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_e      r_state, w_state_nxt;
    op_e         r_op;
    status_e     r_status;
    logic [7:0]  r_a, r_b, r_cnt, w_cnt_inc;
    logic [15:0] r_result;
    logic [3:0]  r_flags, w_flags;
    logic        w_accept, w_dbz, w_done, w_tmo;

    assign w_accept  = cmd_valid && rst_n && r_state == S_IDLE;
    assign w_dbz     = op_e'(cmd_op) == OP_DIV && cmd_b == 8'd0;
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    // r_cnt is zero only in the first WAIT cycle, where a stale done may appear
    assign w_done    = au_done && r_cnt != 8'd0;
    assign w_tmo     = w_cnt_inc >= TMO;

    always_comb begin
        w_flags = '0;
        if (r_op == OP_ADD || r_op == OP_SUB) begin
            w_flags[F_OF]  = au_overflow;
            w_flags[F_NEG] = au_negative;
            w_flags[F_Z]   = au_zero;
            w_flags[F_C]   = au_carry_out;
        end else begin
            w_flags[F_NEG] = au_result[15];
            w_flags[F_Z]   = au_result == 16'd0;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        cmd_ready          = 1'b0;
        rsp_valid          = 1'b0;
        au_startadd        = 1'b0;
        au_startsub        = 1'b0;
        au_startmultiplier = 1'b0;
        au_startdiv        = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = rst_n;
                if (w_accept) w_state_nxt = w_dbz ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                au_startadd        = r_op == OP_ADD;
                au_startsub        = r_op == OP_SUB;
                au_startmultiplier = r_op == OP_MUL;
                au_startdiv        = r_op == OP_DIV;
                if (w_done || w_tmo) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_ADD;
            r_status <= ST_OK;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op     <= op_e'(cmd_op);
                r_a      <= cmd_a;
                r_b      <= cmd_b;
                r_cnt    <= '0;
                r_result <= '0;
                r_flags  <= '0;
                r_status <= w_dbz ? ST_DBZ : ST_OK;
            end
            // one counter serves as timeout timer and reported cycle count
            if (r_state == S_WAIT) begin
                r_cnt <= w_cnt_inc;
                if (w_done) begin
                    r_result <= au_result;
                    r_flags  <= w_flags;
                    r_status <= ST_OK;
                end else if (w_tmo) begin
                    r_status <= ST_TMO;
                end
            end
        end
    end

    assign au_a       = r_a;
    assign au_b       = r_b;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign rsp_op     = r_op;
    assign rsp_status = r_status;
    assign rsp_cycles = r_cnt;
endmodule

// File: tb/tb_au_ctrl.sv
// tb_au_ctrl: directed bench for au_ctrl with a bench-driven AU stub (TIMEOUT=8).
module tb_au_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_a = 8'd0, cmd_b = 8'd0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [1:0]  rsp_op, rsp_status;
    logic [7:0]  rsp_cycles, au_a, au_b;
    logic        au_startadd, au_startsub, au_startmultiplier, au_startdiv;
    logic [15:0] au_result;
    logic        au_overflow, au_negative, au_zero, au_carry_out, au_done;

    logic        stub_en = 1'b0, stale = 1'b0;
    int          stub_lat = 2, stub_cnt = 0;
    logic [15:0] stub_res = 16'd0;
    logic [3:0]  stub_fl = 4'd0;
    int          n_chk = 0, n_fail = 0;
    int          n_hs = 0, n_vcyc = 0, n_rise = 0, n_gap_bad = 0, gap = 0;
    logic        prev_any = 1'b0, seen_rise = 1'b0;
    logic [3:0]  st;
    logic        w_any;

    au_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_op(rsp_op), .rsp_status(rsp_status), .rsp_cycles(rsp_cycles),
        .au_a(au_a), .au_b(au_b),
        .au_startadd(au_startadd), .au_startsub(au_startsub),
        .au_startmultiplier(au_startmultiplier), .au_startdiv(au_startdiv),
        .au_result(au_result), .au_overflow(au_overflow), .au_negative(au_negative),
        .au_zero(au_zero), .au_carry_out(au_carry_out), .au_done(au_done)
    );

    always #5 clk = ~clk;

    // AU stub: done after stub_lat cycles of start high; stale forces a spurious done
    assign st           = {au_startadd, au_startsub, au_startmultiplier, au_startdiv};
    assign w_any        = |st;
    assign au_result    = stub_res;
    assign au_overflow  = stub_fl[3];
    assign au_negative  = stub_fl[2];
    assign au_zero      = stub_fl[1];
    assign au_carry_out = stub_fl[0];
    assign au_done      = (stub_en && w_any && stub_cnt == stub_lat - 1) || stale;

    always @(posedge clk) begin
        stub_cnt <= w_any ? stub_cnt + 1 : 0;
        prev_any <= w_any;
        gap      <= w_any ? 0 : gap + 1;
        if (w_any && !prev_any) begin
            n_rise    <= n_rise + 1;
            seen_rise <= 1'b1;
            if (seen_rise && gap < 2) n_gap_bad <= n_gap_bad + 1;
        end
        if (rsp_valid) n_vcyc <= n_vcyc + 1;
        if (rsp_valid && rsp_ready) n_hs <= n_hs + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else @(negedge clk);
        end
        #1 cmd_valid = 1'b0;
        if (!ok) chk("accept", 0, 1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
    endtask

    task automatic check_rsp(input string tag, input logic [15:0] res, input logic [3:0] fl,
                             input logic [1:0] op, input logic [1:0] sts, input logic [7:0] cyc);
        chk({tag, "_result"}, rsp_result, res);
        chk({tag, "_flags"}, rsp_flags, fl);
        chk({tag, "_op"}, rsp_op, op);
        chk({tag, "_status"}, rsp_status, sts);
        chk({tag, "_cycles"}, rsp_cycles, cyc);
    endtask

    initial begin
        int n, r0, v0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_starts", st, 0);
        chk("rst_ops", {au_a, au_b}, 0);
        check_rsp("rst", 16'h0, 4'h0, 2'd0, 2'd0, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);
        // add 0x7F+0x01 with AU overflow/negative
        stub_en = 1'b1; stub_lat = 2; stub_res = 16'hFF80; stub_fl = 4'b1100;
        send(2'b00, 8'h7F, 8'h01);
        @(negedge clk);
        chk("add_start", st, 4'b1000);
        chk("add_ops", {au_a, au_b}, 16'h7F01);
        chk("add_busy", cmd_ready, 0);
        wait_rsp(n);
        chk("add_lat", n, 2);
        check_rsp("add", 16'hFF80, 4'b1100, 2'b00, 2'b00, 8'd2);
        chk("add_resp_starts", st, 0);
        // sub 0x80-0x80
        stub_res = 16'h0000; stub_fl = 4'b0011;
        send(2'b01, 8'h80, 8'h80);
        @(negedge clk);
        chk("sub_start", st, 4'b0100);
        wait_rsp(n);
        check_rsp("sub", 16'h0000, 4'b0011, 2'b01, 2'b00, 8'd2);
        // back-to-back multiplies; AU add flags must be ignored
        stub_lat = 3; stub_res = 16'hF100; stub_fl = 4'b1001;
        send(2'b10, 8'hF0, 8'h10);
        @(negedge clk);
        chk("mul1_start", st, 4'b0010);
        wait_rsp(n);
        check_rsp("mul1", 16'hF100, 4'b0100, 2'b10, 2'b00, 8'd3);
        stub_res = 16'h0100; stub_fl = 4'b0000;
        send(2'b10, 8'h10, 8'h10);
        @(negedge clk);
        wait_rsp(n);
        check_rsp("mul2", 16'h0100, 4'b0000, 2'b10, 2'b00, 8'd3);
        stub_res = 16'h0000; stub_fl = 4'b1001;
        send(2'b10, 8'h00, 8'h05);
        @(negedge clk);
        wait_rsp(n);
        check_rsp("mul0", 16'h0000, 4'b0010, 2'b10, 2'b00, 8'd3);
        chk("gap", n_gap_bad, 0);
        // divide by zero: immediate response, no start
        r0 = n_rise;
        send(2'b11, 8'h43, 8'h00);
        @(negedge clk);
        chk("dbz_valid", rsp_valid, 1);
        chk("dbz_starts", st, 0);
        check_rsp("dbz", 16'h0000, 4'b0000, 2'b11, 2'b01, 8'd0);
        @(negedge clk);
        chk("dbz_norise", n_rise - r0, 0);
        // divide with stalled response and a pending command
        stub_lat = 4; stub_res = 16'h0803; stub_fl = 4'b0000;
        rsp_ready = 1'b0;
        send(2'b11, 8'h43, 8'h08);
        @(negedge clk);
        chk("div_start", st, 4'b0001);
        wait_rsp(n);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h01; cmd_b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            chk("div_hold_valid", rsp_valid, 1);
            chk("div_hold_result", rsp_result, 16'h0803);
            chk("div_hold_ready", cmd_ready, 0);
            @(negedge clk);
        end
        check_rsp("div", 16'h0803, 4'b0000, 2'b11, 2'b00, 8'd4);
        rsp_ready = 1'b1;
        stub_lat = 2; stub_res = 16'h0002; stub_fl = 4'b0000;
        send(2'b00, 8'h01, 8'h01);
        @(negedge clk);
        chk("pend_ops", {au_a, au_b}, 16'h0101);
        wait_rsp(n);
        check_rsp("pend", 16'h0002, 4'b0000, 2'b00, 2'b00, 8'd2);
        // timeout with a stale done in the first WAIT cycle
        stub_en = 1'b0; stub_res = 16'h1234; stub_fl = 4'b1111;
        send(2'b10, 8'h03, 8'h04);
        @(negedge clk);
        stale = 1'b1;
        @(posedge clk);
        #1 stale = 1'b0;
        @(negedge clk);
        wait_rsp(n);
        chk("tmo_lat", n + 1, 8);
        chk("tmo_starts", st, 0);
        check_rsp("tmo", 16'h0000, 4'b0000, 2'b10, 2'b10, 8'd8);
        // reset during WAIT abandons the command
        send(2'b01, 8'h05, 8'h03);
        @(negedge clk);
        chk("rstw_start", st, 4'b0100);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw_starts", st, 0);
        chk("rstw_valid", rsp_valid, 0);
        chk("rstw_ready", cmd_ready, 0);
        v0 = n_vcyc;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rstw_norsp", n_vcyc - v0, 0);
        chk("rstw_idle", cmd_ready, 1);
        chk("hs_total", n_hs, 9);
        chk("rise_total", n_rise, 9);
        chk("gap_final", n_gap_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
